// File: rtl/pll_mon_pkg.sv
// Shared definitions for the PLL lock monitor: state encodings and default
// parameter values used by the monitor and any block that decodes state_dbg.
package pll_mon_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int MAX_LOSSES_DEF    = 7;
  localparam int CNT_W_DEF         = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-high reset; output is the
// second stage and resets to 0.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: qualifies a synchronized LOCK over STABLE_CYCLES before
// releasing downstream reset, counts lock losses and latches a sticky FAULT.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int MAX_LOSSES    = MAX_LOSSES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lock_raw,
  input  logic             clear_fault,
  output logic             rst_out,
  output logic             ready,
  output logic             fault,
  output logic [CNT_W-1:0] loss_count,
  output logic [2:0]       state_dbg
);

  localparam int                 STAB_W     = $clog2(STABLE_CYCLES) + 1;
  localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOSS_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]     LOSS_LIMIT = (CNT_W + 1)'(MAX_LOSSES);

  logic              lock_s;
  state_e            state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [CNT_W-1:0]  loss_q, loss_d;
  logic [CNT_W-1:0]  loss_inc_s;
  logic              rst_out_q, ready_q, fault_q;

  sync2 u_lock_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (lock_raw),
    .q_o   (lock_s)
  );

  // Next-state, stable-counter and loss-counter logic.
  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    loss_d     = loss_q;
    loss_inc_s = (loss_q == LOSS_SAT) ? loss_q : loss_q + CNT_W'(1);
    case (state_q)
      ST_HOLD: begin
        state_d = ST_WAIT_LOCK;
        stab_d  = '0;
      end
      ST_WAIT_LOCK: begin
        stab_d = '0;
        if (lock_s) begin
          state_d = ST_STABILIZE;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_STABILIZE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_RUN;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          loss_d = loss_inc_s;
          // Fault decision uses the post-increment count.
          if ({1'b0, loss_inc_s} >= LOSS_LIMIT) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_d = ST_WAIT_LOCK;
          loss_d  = '0;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_HOLD;
        stab_d  = '0;
      end
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HOLD;
      stab_q    <= '0;
      loss_q    <= '0;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      stab_q    <= stab_d;
      loss_q    <= loss_d;
      rst_out_q <= (state_d != ST_RUN);
      ready_q   <= (state_d == ST_RUN);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign rst_out    = rst_out_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign loss_count = loss_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed self-checking bench for pll_lock_monitor with STABLE_CYCLES=16,
// MAX_LOSSES=3, CNT_W=4.
module tb_pll_lock_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic       lock_raw;
  logic       clear_fault;
  logic       rst_out;
  logic       ready;
  logic       fault;
  logic [3:0] loss_count;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  pll_lock_monitor #(
    .STABLE_CYCLES (16),
    .MAX_LOSSES    (3),
    .CNT_W         (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .lock_raw    (lock_raw),
    .clear_fault (clear_fault),
    .rst_out     (rst_out),
    .ready       (ready),
    .fault       (fault),
    .loss_count  (loss_count),
    .state_dbg   (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; lock_raw = 1'b0; clear_fault = 1'b0;
    #3;
    n_cmp++; if (rst_out !== 1'b1) begin n_bad++; $display("FAIL reset_rst_out: got %b want 1", rst_out); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_cmp++; if (loss_count !== 4'd0) begin n_bad++; $display("FAIL reset_loss: got %0d want 0", loss_count); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_lock_latency;
    step(1);
    reset = 1'b0; lock_raw = 1'b1;
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL lat_hold: got %0d want 0", state_dbg); end
    step(1);
    n_cmp++; if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL lat_wait: got %0d want 1", state_dbg); end
    step(17);
    n_cmp++; if (ready !== 1'b0 || rst_out !== 1'b1) begin n_bad++; $display("FAIL lat_c18: got ready=%b rst_out=%b want 0/1", ready, rst_out); end
    n_cmp++; if (state_dbg !== 3'd2) begin n_bad++; $display("FAIL lat_c18_state: got %0d want 2", state_dbg); end
    step(1);
    n_cmp++; if (ready !== 1'b1 || rst_out !== 1'b0) begin n_bad++; $display("FAIL lat_c19: got ready=%b rst_out=%b want 1/0", ready, rst_out); end
    n_cmp++; if (state_dbg !== 3'd3) begin n_bad++; $display("FAIL lat_c19_state: got %0d want 3", state_dbg); end
  endtask

  task automatic test_glitch;
    reset = 1'b1; lock_raw = 1'b0;
    step(1);
    reset = 1'b0; lock_raw = 1'b1;
    step(10);
    lock_raw = 1'b0;
    step(1);
    lock_raw = 1'b1;
    step(2);
    n_cmp++; if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL glitch_wait: got %0d want 1", state_dbg); end
    step(1);
    n_cmp++; if (state_dbg !== 3'd2 || loss_count !== 4'd0) begin n_bad++; $display("FAIL glitch_restart: got state=%0d loss=%0d want 2/0", state_dbg, loss_count); end
    step(15);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL glitch_early_run: got %b want 0", ready); end
    step(1);
    n_cmp++; if (ready !== 1'b1 || loss_count !== 4'd0) begin n_bad++; $display("FAIL glitch_run: got ready=%b loss=%0d want 1/0", ready, loss_count); end
  endtask

  task automatic test_loss;
    lock_raw = 1'b0;
    step(2);
    n_cmp++; if (rst_out !== 1'b0) begin n_bad++; $display("FAIL loss_early: got %b want 0", rst_out); end
    lock_raw = 1'b1;
    step(1);
    n_cmp++; if (rst_out !== 1'b1 || ready !== 1'b0) begin n_bad++; $display("FAIL loss_rst_out: got rst_out=%b ready=%b want 1/0", rst_out, ready); end
    n_cmp++; if (loss_count !== 4'd1 || state_dbg !== 3'd1) begin n_bad++; $display("FAIL loss_count: got loss=%0d state=%0d want 1/1", loss_count, state_dbg); end
    step(17);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL loss_rerun_early: got %b want 0", ready); end
    step(1);
    n_cmp++; if (ready !== 1'b1 || state_dbg !== 3'd3) begin n_bad++; $display("FAIL loss_rerun: got ready=%b state=%0d want 1/3", ready, state_dbg); end
  endtask

  task automatic test_clear_in_run;
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    n_cmp++; if (state_dbg !== 3'd3 || loss_count !== 4'd1) begin n_bad++; $display("FAIL clr_run: got state=%0d loss=%0d want 3/1", state_dbg, loss_count); end
    step(1);
    n_cmp++; if (ready !== 1'b1 || loss_count !== 4'd1) begin n_bad++; $display("FAIL clr_run_after: got ready=%b loss=%0d want 1/1", ready, loss_count); end
  endtask

  task automatic test_fault;
    for (int k = 2; k <= 3; k++) begin
      lock_raw = 1'b0;
      step(2);
      lock_raw = 1'b1;
      step(1);
      n_cmp++; if (loss_count !== 4'(k)) begin n_bad++; $display("FAIL fault_loss%0d: got %0d want %0d", k, loss_count, k); end
      n_cmp++; if (state_dbg !== ((k == 3) ? 3'd4 : 3'd1)) begin n_bad++; $display("FAIL fault_state%0d: got %0d want %0d", k, state_dbg, (k == 3) ? 4 : 1); end
      if (k < 3) begin
        step(18);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL fault_rerun%0d: got %b want 1", k, ready); end
      end
    end
    n_cmp++; if (fault !== 1'b1 || rst_out !== 1'b1 || ready !== 1'b0) begin n_bad++; $display("FAIL fault_outs: got fault=%b rst_out=%b ready=%b want 1/1/0", fault, rst_out, ready); end
    step(100);
    n_cmp++; if (state_dbg !== 3'd4 || fault !== 1'b1 || loss_count !== 4'd3) begin n_bad++; $display("FAIL fault_sticky: got state=%0d fault=%b loss=%0d want 4/1/3", state_dbg, fault, loss_count); end
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    n_cmp++; if (state_dbg !== 3'd1 || loss_count !== 4'd0 || fault !== 1'b0) begin n_bad++; $display("FAIL fault_clear: got state=%0d loss=%0d fault=%b want 1/0/0", state_dbg, loss_count, fault); end
    step(1);
    n_cmp++; if (state_dbg !== 3'd2) begin n_bad++; $display("FAIL fault_clear_stab: got %0d want 2", state_dbg); end
  endtask

  task automatic test_async_reset;
    step(5);
    n_cmp++; if (state_dbg !== 3'd2) begin n_bad++; $display("FAIL ar_pre_stab: got %0d want 2", state_dbg); end
    reset = 1'b1;
    #1;
    n_cmp++; if (state_dbg !== 3'd0 || rst_out !== 1'b1 || ready !== 1'b0 || fault !== 1'b0 || loss_count !== 4'd0) begin n_bad++; $display("FAIL ar_stab: got state=%0d rst_out=%b ready=%b fault=%b loss=%0d", state_dbg, rst_out, ready, fault, loss_count); end
    step(1);
    reset = 1'b0;
    step(1);
    n_cmp++; if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL ar_stab_release: got %0d want 1", state_dbg); end
    step(18);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL ar_rerun: got %b want 1", ready); end
    for (int k = 1; k <= 3; k++) begin
      lock_raw = 1'b0;
      step(2);
      lock_raw = 1'b1;
      step(1);
      if (k < 3) step(18);
    end
    n_cmp++; if (fault !== 1'b1 || loss_count !== 4'd3) begin n_bad++; $display("FAIL ar_pre_fault: got fault=%b loss=%0d want 1/3", fault, loss_count); end
    reset = 1'b1;
    #1;
    n_cmp++; if (state_dbg !== 3'd0 || rst_out !== 1'b1 || ready !== 1'b0 || fault !== 1'b0 || loss_count !== 4'd0) begin n_bad++; $display("FAIL ar_fault: got state=%0d rst_out=%b ready=%b fault=%b loss=%0d", state_dbg, rst_out, ready, fault, loss_count); end
    step(1);
    reset = 1'b0;
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL ar_fault_hold: got %0d want 0", state_dbg); end
    step(1);
    n_cmp++; if (state_dbg !== 3'd1 || fault !== 1'b0) begin n_bad++; $display("FAIL ar_fault_release: got state=%0d fault=%b want 1/0", state_dbg, fault); end
  endtask

  initial begin
    test_reset();
    test_lock_latency();
    test_glitch();
    test_loss();
    test_clear_in_run();
    test_fault();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
